// File: rtl/config_axil_write_bridge_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between a host master and the config write bridge.
interface config_axil_write_bridge_if #(
   parameter int unsigned AXIL_ADDR_W = 16,
   parameter int unsigned DATA_W      = 64
);
   logic [AXIL_ADDR_W-1:0] awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [DATA_W-1:0]      wdata;
   logic [DATA_W/8-1:0]    wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/config_axil_write_bridge.sv
// AXI4-Lite write slave: joins AW and W, validates strobe/alignment/range, and turns
// each good write into a one-cycle config-bus pulse while always returning a B response.
module config_axil_write_bridge #(
   parameter int unsigned AXIL_ADDR_W = 16,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned NUM_REGS    = 64,
   parameter int unsigned CONF_ADDR_W = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   config_axil_write_bridge_if.slave s_axil,
   output logic                   conf_valid,
   output logic [CONF_ADDR_W-1:0] conf_addr,
   output logic [DATA_W-1:0]      conf_data
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic                   aw_full_q, aw_full_d;
   logic [AXIL_ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic                   w_full_q, w_full_d;
   logic [DATA_W-1:0]      w_data_q, w_data_d;
   logic [DATA_W/8-1:0]    w_strb_q, w_strb_d;
   logic                   bvalid_q, bvalid_d;
   logic [1:0]             bresp_q, bresp_d;
   logic                   conf_valid_q, conf_valid_d;
   logic [CONF_ADDR_W-1:0] conf_addr_q, conf_addr_d;
   logic [DATA_W-1:0]      conf_data_q, conf_data_d;

   logic                   fire;
   logic                   aw_take, w_take;
   logic [AXIL_ADDR_W-1:0] word_idx;
   logic                   req_ok;

   // A slot emptied by this edge's fire may be refilled on the same edge,
   // which is what sustains one write per cycle.
   assign fire             = aw_full_q && w_full_q && (!bvalid_q || s_axil.bready);
   assign s_axil.awready   = !aw_full_q || fire;
   assign s_axil.wready    = !w_full_q || fire;
   assign aw_take          = s_axil.awvalid && s_axil.awready;
   assign w_take           = s_axil.wvalid && s_axil.wready;

   // Full-width index so upper address bits fail the range check instead of aliasing.
   assign word_idx = aw_addr_q >> OFF_W;
   assign req_ok   = (aw_addr_q[OFF_W-1:0] == '0) && (w_strb_q == '1)
                     && (word_idx < AXIL_ADDR_W'(NUM_REGS));

   always_comb begin
      aw_full_d    = aw_full_q;
      aw_addr_d    = aw_addr_q;
      w_full_d     = w_full_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      conf_valid_d = 1'b0;
      conf_addr_d  = conf_addr_q;
      conf_data_d  = conf_data_q;

      if (bvalid_q && s_axil.bready) begin
         bvalid_d = 1'b0;
      end
      if (fire) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = req_ok ? 2'b00 : 2'b10;
         if (req_ok) begin
            conf_valid_d = 1'b1;
            conf_addr_d  = word_idx[CONF_ADDR_W-1:0];
            conf_data_d  = w_data_q;
         end
      end
      if (aw_take) begin
         aw_full_d = 1'b1;
         aw_addr_d = s_axil.awaddr;
      end
      if (w_take) begin
         w_full_d = 1'b1;
         w_data_d = s_axil.wdata;
         w_strb_d = s_axil.wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_full_q    <= 1'b0;
         aw_addr_q    <= '0;
         w_full_q     <= 1'b0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         conf_valid_q <= 1'b0;
         conf_addr_q  <= '0;
         conf_data_q  <= '0;
      end else begin
         aw_full_q    <= aw_full_d;
         aw_addr_q    <= aw_addr_d;
         w_full_q     <= w_full_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         conf_valid_q <= conf_valid_d;
         conf_addr_q  <= conf_addr_d;
         conf_data_q  <= conf_data_d;
      end
   end

   assign s_axil.bvalid = bvalid_q;
   assign s_axil.bresp  = bresp_q;
   assign conf_valid    = conf_valid_q;
   assign conf_addr     = conf_addr_q;
   assign conf_data     = conf_data_q;
endmodule
